// File: rtl/load_value_predictor_if.sv
// Load value predictor handshake bundle: lookup request, prediction, resolve, recovery and status.
interface load_value_predictor_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 4
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic                  req_valid;
  logic [DATA_WIDTH-1:0] req_pc;
  logic                  req_ready;
  logic                  pred_valid;
  logic [DATA_WIDTH-1:0] pred_data;
  logic                  resolve_valid;
  logic [DATA_WIDTH-1:0] resolve_data;
  logic                  flush;
  logic                  recover;
  logic [DATA_WIDTH-1:0] recover_pc;
  logic [CNT_W-1:0]      inflight;
  logic                  err;
  logic [31:0]           pred_count;
  logic [31:0]           mispred_count;

  modport master (
    output req_valid, req_pc, resolve_valid, resolve_data, flush,
    input  req_ready, pred_valid, pred_data, recover, recover_pc,
           inflight, err, pred_count, mispred_count
  );

  modport slave (
    input  req_valid, req_pc, resolve_valid, resolve_data, flush,
    output req_ready, pred_valid, pred_data, recover, recover_pc,
           inflight, err, pred_count, mispred_count
  );
endinterface

// File: rtl/load_value_predictor.sv
// Direct-mapped load value predictor with in-order verification queue; LVP_STATS_EN adds counters.
// Prediction is combinational with the accepting request; recover pulses one cycle after a bad resolve, and req_ready drops when the queue is full or during recover.
module load_value_predictor #(
  parameter int ENTRIES      = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int CONF_BITS    = 2,
  parameter int CONF_THRESH  = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                   clk,
  input logic                   rst,
  load_value_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] value;
    logic [CONF_BITS-1:0]  conf;
  } entry_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pred;
    logic                  flag;
  } qent_t;

  entry_t tbl [ENTRIES];
  qent_t  q   [MAX_INFLIGHT];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  recover_q;
  logic [DATA_WIDTH-1:0] recover_pc_q;
  logic                  err_q;

  logic                  full;
  logic                  empty;
  logic                  accept;
  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  entry_t                req_ent;
  logic                  pred_hit;
  logic [DATA_WIDTH-1:0] pred_val;

  logic                  pop;
  qent_t                 head_ent;
  logic [IDX_W-1:0]      res_idx;
  logic [TAG_W-1:0]      res_tag;
  entry_t                res_ent;
  logic                  res_hit;
  logic                  mispred;

  assign full  = (count == CNT_W'(MAX_INFLIGHT));
  assign empty = (count == '0);

  // Ready depends only on registered state; flush still wins over an accept.
  assign bus.req_ready = ~full & ~recover_q;
  assign accept        = bus.req_valid & ~full & ~recover_q & ~bus.flush;

  assign req_idx  = bus.req_pc[IDX_W+1:2];
  assign req_tag  = bus.req_pc[DATA_WIDTH-1:IDX_W+2];
  assign req_ent  = tbl[req_idx];
  assign pred_hit = accept & req_ent.valid & (req_ent.tag == req_tag) &
                    (req_ent.conf >= CONF_BITS'(CONF_THRESH));
  assign pred_val = pred_hit ? req_ent.value : '0;

  assign bus.pred_valid = pred_hit;
  assign bus.pred_data  = pred_val;

  assign pop      = bus.resolve_valid & ~empty & ~recover_q & ~bus.flush;
  assign head_ent = q[head];
  assign res_idx  = head_ent.pc[IDX_W+1:2];
  assign res_tag  = head_ent.pc[DATA_WIDTH-1:IDX_W+2];
  assign res_ent  = tbl[res_idx];
  assign res_hit  = res_ent.valid & (res_ent.tag == res_tag);
  assign mispred  = pop & head_ent.flag & (bus.resolve_data != head_ent.pred);

  // Training reads the head entry; a same-cycle lookup still sees the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].conf  <= '0;
      end
    end else if (pop) begin
      if (res_hit) begin
        if (bus.resolve_data == res_ent.value) begin
          if (res_ent.conf != {CONF_BITS{1'b1}})
            tbl[res_idx].conf <= res_ent.conf + CONF_BITS'(1);
        end else begin
          tbl[res_idx].value <= bus.resolve_data;
          tbl[res_idx].conf  <= '0;
        end
      end else begin
        tbl[res_idx] <= '{valid: 1'b1, tag: res_tag, value: bus.resolve_data, conf: '0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      q[tail] <= '{pc: bus.req_pc, pred: pred_val, flag: pred_hit};
  end

  // The recover cycle itself blocks push/pop, then empties the whole queue.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || recover_q) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept)
        tail <= tail + PTR_W'(1);
      if (pop)
        head <= head + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      recover_q    <= 1'b0;
      recover_pc_q <= '0;
      err_q        <= 1'b0;
    end else begin
      recover_q <= mispred;
      if (mispred)
        recover_pc_q <= head_ent.pc;
      if (bus.resolve_valid & empty & ~recover_q & ~bus.flush)
        err_q <= 1'b1;
    end
  end

  assign bus.recover    = recover_q;
  assign bus.recover_pc = recover_pc_q;
  assign bus.inflight   = count;
  assign bus.err        = err_q;

`ifdef LVP_STATS_EN
  logic [31:0] pred_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (pred_hit)
        pred_cnt_q <= pred_cnt_q + 32'd1;
      if (recover_q)
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bus.pred_count    = pred_cnt_q;
  assign bus.mispred_count = mispred_cnt_q;
`else
  assign bus.pred_count    = '0;
  assign bus.mispred_count = '0;
`endif

endmodule
